// File: rtl/ddd_responder_tmb.sv
// Responder side of the 3D3444 serial delay-chip link: shifts in a 60-bit frame,
// latches oe and twelve 4-bit channel delays on the address strobe, and loops sr[0] back.
module ddd_responder_tmb (
  input  logic        clock,
  input  logic        global_reset,
  input  logic        serial_clock,
  input  logic        serial_data,
  input  logic        adr_latch,
  output logic        serial_readback,
  output logic [11:0] oe,
  output logic [3:0]  delay_ch0,
  output logic [3:0]  delay_ch1,
  output logic [3:0]  delay_ch2,
  output logic [3:0]  delay_ch3,
  output logic [3:0]  delay_ch4,
  output logic [3:0]  delay_ch5,
  output logic [3:0]  delay_ch6,
  output logic [3:0]  delay_ch7,
  output logic [3:0]  delay_ch8,
  output logic [3:0]  delay_ch9,
  output logic [3:0]  delay_ch10,
  output logic [3:0]  delay_ch11,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  // state    | meaning
  // st_idle  | waiting for the first serial clock rise or a strobe
  // st_shift | accepting frame bits
  // st_latch | one cycle: judge bit count, load outputs or flag error
  // st_hold  | strobe still low, wait for it to return high
  typedef enum logic [1:0] {st_idle, st_shift, st_latch, st_hold} state_t;

  state_t      state;
  logic        sc_ff, sd_ff, al_ff, sc_prev, al_prev;
  logic [59:0] sr;
  logic [6:0]  bit_cnt;
  logic [3:0]  dly_q [12];
  logic        rise, accept, latch_edge;

  assign rise       = sc_ff & ~sc_prev;
  assign accept     = rise & al_ff;
  assign latch_edge = ~al_ff & al_prev;

  // Fields are sent MSB first, so the lowest sr index of a nibble is its MSB.
  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  assign delay_ch0  = dly_q[0];
  assign delay_ch1  = dly_q[1];
  assign delay_ch2  = dly_q[2];
  assign delay_ch3  = dly_q[3];
  assign delay_ch4  = dly_q[4];
  assign delay_ch5  = dly_q[5];
  assign delay_ch6  = dly_q[6];
  assign delay_ch7  = dly_q[7];
  assign delay_ch8  = dly_q[8];
  assign delay_ch9  = dly_q[9];
  assign delay_ch10 = dly_q[10];
  assign delay_ch11 = dly_q[11];

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state           <= st_idle;
      sc_ff           <= 1'b0;
      sc_prev         <= 1'b0;
      sd_ff           <= 1'b0;
      al_ff           <= 1'b1;
      al_prev         <= 1'b1;
      sr              <= '0;
      bit_cnt         <= '0;
      oe              <= '0;
      for (int i = 0; i < 12; i++) dly_q[i] <= '0;
      serial_readback <= 1'b0;
      frame_ok        <= 1'b0;
      frame_err       <= 1'b0;
      err_cnt         <= '0;
      busy            <= 1'b0;
    end else begin
      sc_ff           <= serial_clock;
      sd_ff           <= serial_data;
      al_ff           <= adr_latch;
      sc_prev         <= sc_ff;
      al_prev         <= al_ff;
      serial_readback <= sr[0];
      frame_ok        <= 1'b0;
      frame_err       <= 1'b0;
      busy            <= 1'b0;

      // sr is deliberately left intact by a latch so a verify pass reads the frame back.
      if (accept) sr <= {sd_ff, sr[59:1]};

      if (state == st_latch)
        bit_cnt <= '0;
      else if (accept && bit_cnt != 7'd127)
        bit_cnt <= bit_cnt + 7'd1;

      case (state)
        st_idle: begin
          if (accept) begin
            state <= st_shift;
            busy  <= 1'b1;
          end else if (latch_edge) begin
            state <= st_latch;
          end
        end
        st_shift: begin
          if (latch_edge) state <= st_latch;
          else            busy  <= 1'b1;
        end
        st_latch: begin
          if (bit_cnt == 7'd60) begin
            oe        <= {rev4(sr[3:0]), rev4(sr[23:20]), rev4(sr[43:40])};
            dly_q[8]  <= rev4(sr[7:4]);
            dly_q[9]  <= rev4(sr[11:8]);
            dly_q[10] <= rev4(sr[15:12]);
            dly_q[11] <= rev4(sr[19:16]);
            dly_q[4]  <= rev4(sr[27:24]);
            dly_q[5]  <= rev4(sr[31:28]);
            dly_q[6]  <= rev4(sr[35:32]);
            dly_q[7]  <= rev4(sr[39:36]);
            dly_q[0]  <= rev4(sr[47:44]);
            dly_q[1]  <= rev4(sr[51:48]);
            dly_q[2]  <= rev4(sr[55:52]);
            dly_q[3]  <= rev4(sr[59:56]);
            frame_ok  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
          state <= st_hold;
        end
        st_hold: begin
          if (al_ff) state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_ddd_responder_tmb.sv
// Bench for ddd_responder_tmb: vector table, hand sequences for readback/reset/strobe
// corners, and random frames checked against a bit-history model of the link.
module tb_ddd_responder_tmb;

  logic        clock = 1'b0;
  logic        global_reset = 1'b1;
  logic        serial_clock = 1'b0;
  logic        serial_data = 1'b0;
  logic        adr_latch = 1'b1;
  logic        serial_readback, frame_ok, frame_err, busy;
  logic [11:0] oe;
  logic [7:0]  err_cnt;
  logic [3:0]  delay_ch0, delay_ch1, delay_ch2, delay_ch3, delay_ch4, delay_ch5;
  logic [3:0]  delay_ch6, delay_ch7, delay_ch8, delay_ch9, delay_ch10, delay_ch11;
  logic [3:0]  dly_out [12];

  ddd_responder_tmb dut (
    .clock(clock), .global_reset(global_reset), .serial_clock(serial_clock),
    .serial_data(serial_data), .adr_latch(adr_latch), .serial_readback(serial_readback),
    .oe(oe), .delay_ch0(delay_ch0), .delay_ch1(delay_ch1), .delay_ch2(delay_ch2),
    .delay_ch3(delay_ch3), .delay_ch4(delay_ch4), .delay_ch5(delay_ch5),
    .delay_ch6(delay_ch6), .delay_ch7(delay_ch7), .delay_ch8(delay_ch8),
    .delay_ch9(delay_ch9), .delay_ch10(delay_ch10), .delay_ch11(delay_ch11),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  assign dly_out[0] = delay_ch0;   assign dly_out[1] = delay_ch1;
  assign dly_out[2] = delay_ch2;   assign dly_out[3] = delay_ch3;
  assign dly_out[4] = delay_ch4;   assign dly_out[5] = delay_ch5;
  assign dly_out[6] = delay_ch6;   assign dly_out[7] = delay_ch7;
  assign dly_out[8] = delay_ch8;   assign dly_out[9] = delay_ch9;
  assign dly_out[10] = delay_ch10; assign dly_out[11] = delay_ch11;

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ok_seen = 0;
  int err_seen = 0;

  always @(negedge clock) begin
    if (frame_ok)  ok_seen++;
    if (frame_err) err_seen++;
  end

  // Frame word: ch n at [4n+:4], oe at [59:48]. Send order by nibble slot
  // (14/13/12 = oe[11:8]/oe[7:4]/oe[3:0]); each nibble goes MSB first.
  localparam int send_order [15] = '{14, 8, 9, 10, 11, 13, 4, 5, 6, 7, 12, 0, 1, 2, 3};

  bit          hist[$];
  int          mcnt;
  logic [59:0] mvec;
  int          merr;

  function automatic logic [5:0] vec_idx(input int p);
    return 6'(4 * send_order[p / 4] + 3 - (p % 4));
  endfunction

  function automatic bit enc_bit(input logic [59:0] v, input int p);
    return v[vec_idx(p)];
  endfunction

  function automatic logic [59:0] decode_hist();
    logic [59:0] v = '0;
    for (int p = 0; p < 60; p++) v[vec_idx(p)] = hist[p];
    return v;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 60; i++) hist.push_back(1'b0);
    mcnt = 0;
    mvec = '0;
    merr = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [59:0] v);
    check({tag, " oe"}, 64'(oe), 64'(v[59:48]));
    for (int n = 0; n < 12; n++)
      check($sformatf("%s dly%0d", tag, n), 64'(dly_out[n]), 64'(v[4*n +: 4]));
  endtask

  task automatic send_bit(input bit d);
    serial_data = d;
    repeat (2) @(negedge clock);
    serial_clock = 1'b1;
    repeat (3) @(negedge clock);
    serial_clock = 1'b0;
    repeat (2) @(negedge clock);
    if (adr_latch) begin
      hist.push_back(d);
      void'(hist.pop_front());
      if (mcnt < 127) mcnt++;
    end
  endtask

  task automatic send_frame(input logic [59:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(enc_bit(v, i % 60));
  endtask

  task automatic do_latch(input int toggles);
    int ok0;
    int err0;
    bit exp_ok;
    ok0 = ok_seen;
    err0 = err_seen;
    adr_latch = 1'b0;
    repeat (4) @(negedge clock);
    for (int t = 0; t < toggles; t++) send_bit(1'b1);
    adr_latch = 1'b1;
    repeat (4) @(negedge clock);
    exp_ok = (mcnt == 60);
    if (exp_ok) mvec = decode_hist();
    else if (merr < 255) merr++;
    mcnt = 0;
    check("latch ok pulses", 64'(ok_seen - ok0), 64'(exp_ok));
    check("latch err pulses", 64'(err_seen - err0), 64'(!exp_ok));
    check("latch err_cnt", 64'(err_cnt), 64'(merr));
    check("latch busy", 64'(busy), 64'(0));
    check_outputs("latch", mvec);
  endtask

  typedef struct {
    int          nbits;
    logic [59:0] vec;
    bit          exp_ok;
    int          exp_err_cnt;
  } row_t;

  row_t        rows [7];
  logic [59:0] last_good;
  logic [59:0] rvec;
  int          rn;
  int          ok0, err0;

  initial begin
    rows[0] = '{60,  {12'hFFF, 48'hBA9876543210}, 1'b1, 0};
    rows[1] = '{59,  {12'h123, 48'h0123456789AB}, 1'b0, 1};
    rows[2] = '{60,  {12'hA5C, 48'h3C5A96F0E1D2}, 1'b1, 1};
    rows[3] = '{61,  {12'h0F0, 48'hFFFF00001234}, 1'b0, 2};
    rows[4] = '{0,   60'h0,                       1'b0, 3};
    rows[5] = '{130, {12'h5A5, 48'h123456789ABC}, 1'b0, 4};
    rows[6] = '{60,  {12'h000, 48'hFFFFFFFFFFFF}, 1'b1, 4};

    model_reset();
    repeat (3) @(negedge clock);
    check("reset readback", 64'(serial_readback), 64'(0));
    check("reset frame_ok", 64'(frame_ok), 64'(0));
    check("reset frame_err", 64'(frame_err), 64'(0));
    check("reset err_cnt", 64'(err_cnt), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check_outputs("reset", 60'h0);
    global_reset = 1'b0;
    repeat (2) @(negedge clock);

    last_good = '0;
    for (int r = 0; r < 7; r++) begin
      ok0 = ok_seen;
      err0 = err_seen;
      send_frame(rows[r].vec, rows[r].nbits);
      check($sformatf("row%0d busy", r), 64'(busy), 64'(rows[r].nbits > 0));
      do_latch(0);
      if (rows[r].exp_ok) last_good = rows[r].vec;
      check($sformatf("row%0d ok", r), 64'(ok_seen - ok0), 64'(rows[r].exp_ok));
      check($sformatf("row%0d err", r), 64'(err_seen - err0), 64'(!rows[r].exp_ok));
      check($sformatf("row%0d err_cnt", r), 64'(err_cnt), 64'(rows[r].exp_err_cnt));
      check_outputs($sformatf("row%0d", r), last_good);
    end

    // Readback of the basic frame: first bit out is oe[11].
    send_frame(rows[0].vec, 60);
    do_latch(0);
    check("basic delay_ch5", 64'(delay_ch5), 64'(5));
    for (int p = 0; p < 60; p++) begin
      check($sformatf("readback bit%0d", p), 64'(serial_readback), 64'(enc_bit(rows[0].vec, p)));
      send_bit(1'b0);
    end

    // Serial clock toggled with strobe low must neither count nor shift.
    do_latch(3);
    check("strobe-low no shift", 64'(serial_readback), 64'(0));

    // Reset mid-frame discards the partial frame.
    send_frame(rows[2].vec, 30);
    check("midframe busy", 64'(busy), 64'(1));
    global_reset = 1'b1;
    repeat (2) @(negedge clock);
    global_reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("midreset err_cnt", 64'(err_cnt), 64'(0));
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset readback", 64'(serial_readback), 64'(0));
    check_outputs("midreset", 60'h0);
    send_frame(rows[3].vec, 60);
    do_latch(0);
    check_outputs("after reset", rows[3].vec);

    for (int it = 0; it < 40; it++) begin
      rvec = {28'($urandom), $urandom};
      case ($urandom_range(0, 3))
        0, 1:    rn = 60;
        2:       rn = $urandom_range(0, 1) ? 59 : 61;
        default: rn = $urandom_range(0, 70);
      endcase
      send_frame(rvec, rn);
      do_latch($urandom_range(0, 2));
    end

    for (int i = 0; i < 256; i++) do_latch(0);
    check("err_cnt saturated", 64'(err_cnt), 64'(8'hFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddd_responder_tmb.md
DDD_RESPONDER_TMB -- requirements
Module: ddd_responder_tmb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock, global_reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: fabric clock, same domain as the DDD initiator.
- global_reset, in, 1: synchronous active-high reset.
- serial_clock, in, 1: 3D3444 serial clock from the initiator.
- serial_data, in, 1: 3D3444 serial data from the initiator.
- adr_latch, in, 1: 3D3444 address strobe, active low.
- serial_readback, out, 1: chain output to the initiator's verify input.
- oe, out, 12: latched output enables.
- delay_ch0 .. delay_ch11, out, 4 each: latched channel delay steps.
- frame_ok, out, 1: one-cycle pulse when a valid 60-bit frame is latched.
- frame_err, out, 1: one-cycle pulse when a frame is latched with the wrong bit count.
- err_cnt, out, 8: saturating count of bad frames.
- busy, out, 1: high while the block is in state shift.

Function
REQ-003 serial_clock, serial_data and adr_latch SHALL be registered once (sc_ff, sd_ff, al_ff), and sc_ff and al_ff SHALL be registered a second time (sc_prev, al_prev).
REQ-004 A rise SHALL be detected when sc_ff=1 and sc_prev=0; a latch edge SHALL be detected when al_ff=0 and al_prev=1.
REQ-005 On each rise with al_ff=1, the 60-bit register sr SHALL shift right: sr[59] <= sd_ff, sr[58:0] <= sr[59:1].
REQ-006 A rise occurring while al_ff=0 SHALL be ignored: no shift and no count.
REQ-007 The 7-bit counter bit_cnt SHALL increment on each accepted rise, saturate at 127, and clear on the cycle after a latch.
REQ-008 The decode map SHALL place the first bit sent at sr[0]. Fields SHALL be MSB first within each nibble:
- sr[3:0] = oe[11:8]
- sr[19:4] = ch8..ch11
- sr[23:20] = oe[7:4]
- sr[39:24] = ch4..ch7
- sr[43:40] = oe[3:0]
- sr[59:44] = ch0..ch3
- Example: sr[4] = delay_ch8[3], sr[7] = delay_ch8[0].
REQ-009 The state machine SHALL have the states idle, shift, latch and hold; any other encoding SHALL return to idle.
REQ-010 Transitions SHALL be:
- idle -> shift on an accepted rise.
- idle -> latch on a latch edge.
- shift -> latch on a latch edge.
- latch -> hold unconditionally, after one cycle.
- hold -> idle when al_ff=1.
REQ-011 In latch with bit_cnt==60, the block SHALL load oe and delay_ch0..11 from sr and pulse frame_ok.
REQ-012 In latch with bit_cnt!=60 (including 0 and saturated 127), the outputs SHALL hold their previous values, frame_err SHALL pulse, and err_cnt SHALL increment, saturating at 255.
REQ-013 sr SHALL NOT be cleared by a latch, so that a verify pass shifts the previous frame back out.
REQ-014 serial_readback SHALL equal sr[0], registered, so that it updates one clock after each shift.
REQ-015 busy SHALL be registered and high only in state shift.

Reset
REQ-016 On global_reset, the state SHALL be idle, and all of the following SHALL be 0: sr, bit_cnt, oe, delay_ch0..11, serial_readback, frame_ok, frame_err, err_cnt, busy.
REQ-017 On global_reset, sc_ff and sc_prev SHALL be 0, and al_ff and al_prev SHALL be 1, so that no false edge occurs after reset.
REQ-018 A reset asserted mid-frame SHALL discard the partial frame; outputs SHALL return to 0 and the next frame SHALL start from bit_cnt=0.

Verification
REQ-019 Basic frame: oe=12'hFFF, delay_chN=N (N=0..11), sent by the initiator serial pattern, 60 clocks then adr_latch low -> frame_ok pulses once, delay_ch5=4'h5, oe=12'hFFF, err_cnt=0.
REQ-020 Short frame: 59 bits then latch -> frame_err pulses, outputs are unchanged from the prior frame, err_cnt=1.
REQ-021 Readback: after the frame of REQ-019, clock 60 more bits of 0 -> serial_readback reproduces the 60 prior bits in send order, starting with oe[11]=1.
REQ-022 Saturation: 130 rises then latch -> frame_err pulses. Separately, 256 bad frames -> err_cnt=8'hFF.
REQ-023 Reset mid-frame: global_reset after 30 bits, then a full 60-bit frame -> frame_ok pulses and values match the second frame only.
REQ-024 Rise during adr_latch low: toggle serial_clock while adr_latch=0 -> bit_cnt is unchanged and there is no shift.
